snake_body_tracker: RTL
=======================

Name: snake_body_tracker

Overview:
Owns the snake's segment coordinates, moves the snake one cell per movement tick, and detects collisions. It produces the `body` array and the one-cycle `good_coll` strobe that the apple generator consumes, and it takes the current apple coordinate back from that generator. It also answers per-pixel "is this cell snake" queries from the display scan, with one cycle of latency.

Parameters:
MAX_LEN, 50, number of body slots; equals the width of the `body` array.
LEN_W, 6, width of `length`; must satisfy 2^LEN_W > MAX_LEN.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  leaves IDLE on the next edge
tick  in  1  single-cycle movement strobe
dir  in  2  requested direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
apple_cord  in  8  current apple cell, packed {x,y}
x  in  4  display query column
y  in  4  display query row
body  out  MAX_LEN x 8  segment cells, packed {x,y}; index 0 is the head
length  out  LEN_W  number of live segments
good_coll  out  1  one-cycle pulse: the head just entered the apple cell
bad_coll  out  1  one-cycle pulse: wall or self hit
game_over  out  1  level, high while in state DEAD
snake_pixel  out  1  registered: {x,y} is a live segment

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is checked at every posedge and overrides all other activity, including mid-move.
- Reset values:
  - state = IDLE; length = 3.
  - body[0]=8'h48, body[1]=8'h38, body[2]=8'h28.
  - body[3..MAX_LEN-1] = 8'h28.
  - current direction = right.
  - good_coll = bad_coll = game_over = snake_pixel = 0.
- Unused-slot rule: every slot with index >= length always holds a copy of the tail, body[length-1]. No slot ever holds an out-of-grid or sentinel value, so a consumer can compare against all MAX_LEN slots safely.
- States:
  - IDLE: tick is ignored. start=1 moves to RUN.
  - RUN: each tick performs one move.
  - DEAD: everything is frozen and game_over=1. Only reset leaves DEAD.
- Move, evaluated on the edge where tick=1 in RUN:
  - Direction: if dir is the exact reverse of the current direction, dir is ignored and the current direction is kept. Otherwise the current direction becomes dir.
  - next_head = body[0] stepped one cell in the current direction.
  - Wall hit: the step would leave 0..15 on either axis (no wrap-around).
  - grow = (next_head == apple_cord).
  - Self hit: next_head equals body[i] for i in 0..length-1 when grow=1, or i in 0..length-2 when grow=0. The tail vacates its cell in the same move.
  - On any hit: bad_coll pulses, state goes to DEAD, and body and length are unchanged. This applies even if grow=1; bad wins and good_coll stays 0.
  - On no hit: body shifts (body[i] <= body[i-1], body[0] <= next_head), and the unused-slot rule is reapplied.
  - If grow=1: good_coll pulses and length increments, saturating at MAX_LEN. At saturation the shift still occurs and good_coll still pulses.
- Latency: the registered outputs reflect the move on the edge that samples tick=1; the pulses are high for exactly that one following cycle. tick=0, or tick in IDLE or DEAD, produces no pulses.
- snake_pixel: registered compare of {x,y} against body[0..length-1], one cycle of latency, valid in every state.
- Width rule: coordinate arithmetic uses 5-bit signed intermediates so that out-of-range steps are detected before truncation.

Test Plan:
- Reset: assert reset for 2 cycles → body[0..2]=48,38,28; all of body[3..49]=28; length=3; all flags 0; a tick in IDLE leaves body unchanged.
- Movement: start, then 3 ticks with dir=11 → body[0]=78, body[1]=68, body[2]=58, length=3, no pulses.
- Eat: apple_cord=58, start, tick with dir=11 → good_coll high for exactly 1 cycle; length=4; body[0..3]=58,48,38,28; body[4..49]=28.
- Reversal: start, tick with dir=10 → head moves right to 58, no collision.
- Wall: head at 48, direction up, 8 ticks → head reaches 40, then the 9th tick gives bad_coll for 1 cycle, game_over=1, and body stays frozen at 40 through further ticks.
- Self hit and mid-run reset: grow to length 5 and steer down, left, up → bad_coll, DEAD. Then assert reset for 1 cycle mid-tick → reset values restored, state IDLE.
- Pixel: after reset, query {x,y}=38 → snake_pixel=1 one cycle later; query 99 → 0.

Source files
------------

// File: rtl/snake_body_tracker_if.sv
// Bus between the snake body tracker and its users (game controller,
// apple generator, display scan).
//
// Signalling: there is no valid/ready flow control on this bus. start and
// tick are single-cycle strobes, sampled on the rising clock edge.
// apple_cord, x and y are levels that are sampled on every edge.
// On the slave side, good_coll and bad_coll are one-cycle pulses.
// body, length, game_over and snake_pixel are registered levels.
interface snake_body_tracker_if #(
  parameter int MAX_LEN = 50,
  parameter int LEN_W   = 6
);
  logic                    start;
  logic                    tick;
  logic [1:0]              dir;
  logic [7:0]              apple_cord;
  logic [3:0]              x;
  logic [3:0]              y;
  logic [MAX_LEN-1:0][7:0] body;
  logic [LEN_W-1:0]        length;
  logic                    good_coll;
  logic                    bad_coll;
  logic                    game_over;
  logic                    snake_pixel;

  modport master (
    output start, tick, dir, apple_cord, x, y,
    input  body, length, good_coll, bad_coll, game_over, snake_pixel
  );

  modport slave (
    input  start, tick, dir, apple_cord, x, y,
    output body, length, good_coll, bad_coll, game_over, snake_pixel
  );
endinterface

// File: rtl/snake_body_tracker.sv
// Snake body tracker. It holds the segment cells, advances the snake by
// one cell per tick, and flags apple, wall and self collisions. It also
// answers display "is this cell snake" queries with one cycle of latency.
// Each slot at or beyond length mirrors the tail cell.
module snake_body_tracker #(
  parameter int MAX_LEN = 50,
  parameter int LEN_W   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  snake_body_tracker_if.slave  bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_DOWN  = 2'b01;
  localparam logic [1:0] D_LEFT  = 2'b10;
  localparam logic [1:0] D_RIGHT = 2'b11;

  state_t                  r_state;
  logic [1:0]              r_dir;
  logic [MAX_LEN-1:0][7:0] r_body;
  logic [LEN_W-1:0]        r_len;
  logic                    r_good;
  logic                    r_bad;
  logic                    r_pixel;

  logic [1:0]              w_dir;
  logic signed [4:0]       w_hx;
  logic signed [4:0]       w_hy;
  logic                    w_wall;
  logic [7:0]              w_next;
  logic                    w_grow;
  logic                    w_self;
  logic                    w_pix;
  logic [LEN_W-1:0]        w_lim;
  logic [LEN_W-1:0]        w_len_nx;
  logic [7:0]              w_tail;
  logic [MAX_LEN-1:0][7:0] w_shift;
  logic [MAX_LEN-1:0][7:0] w_body_nx;

  // Candidate move: resolve the direction, step the head, classify hits,
  // and build the shifted body with the tail copied into the unused slots.
  always_comb begin
    // Reversal codes differ only in bit 0 (up/down, left/right).
    w_dir = (bus.dir == {r_dir[1], ~r_dir[0]}) ? r_dir : bus.dir;
    // A 5-bit signed step lets -1 and 16 both show up as bit 4 set.
    w_hx  = signed'({1'b0, r_body[0][7:4]});
    w_hy  = signed'({1'b0, r_body[0][3:0]});
    case (w_dir)
      D_UP:    w_hy = w_hy - 5'sd1;
      D_DOWN:  w_hy = w_hy + 5'sd1;
      D_LEFT:  w_hx = w_hx - 5'sd1;
      default: w_hx = w_hx + 5'sd1;
    endcase
    w_wall = w_hx[4] | w_hy[4];
    w_next = {w_hx[3:0], w_hy[3:0]};
    w_grow = (w_next == bus.apple_cord);
    // When the snake does not grow, the tail leaves its cell in this same
    // move, so the tail cell is not counted as an obstacle.
    w_lim  = w_grow ? r_len : r_len - LEN_W'(1);
    w_self = 1'b0;
    w_pix  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < w_lim) && (r_body[i] == w_next))
        w_self = 1'b1;
      if ((LEN_W'(i) < r_len) && (r_body[i] == {bus.x, bus.y}))
        w_pix = 1'b1;
    end
    w_len_nx = (w_grow && (r_len < LEN_W'(MAX_LEN))) ? r_len + LEN_W'(1) : r_len;
    w_shift[0] = w_next;
    for (int i = 1; i < MAX_LEN; i++)
      w_shift[i] = r_body[i-1];
    w_tail = w_shift[w_len_nx - LEN_W'(1)];
    for (int i = 0; i < MAX_LEN; i++)
      w_body_nx[i] = (LEN_W'(i) < w_len_nx) ? w_shift[i] : w_tail;
  end

  // Game FSM with registered body, length, collision pulses and pixel hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dir   <= D_RIGHT;
      r_len   <= LEN_W'(3);
      for (int i = 2; i < MAX_LEN; i++)
        r_body[i] <= 8'h28;
      r_body[0] <= 8'h48;
      r_body[1] <= 8'h38;
      r_good  <= 1'b0;
      r_bad   <= 1'b0;
      r_pixel <= 1'b0;
    end else begin
      r_good  <= 1'b0;
      r_bad   <= 1'b0;
      r_pixel <= w_pix;
      case (r_state)
        S_IDLE: begin
          if (bus.start)
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (bus.tick) begin
            r_dir <= w_dir;
            if (w_wall || w_self) begin
              // Any hit beats an apple: freeze the body and report bad only.
              r_bad   <= 1'b1;
              r_state <= S_DEAD;
            end else begin
              r_body <= w_body_nx;
              r_len  <= w_len_nx;
              r_good <= w_grow;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.body        = r_body;
  assign bus.length      = r_len;
  assign bus.good_coll   = r_good;
  assign bus.bad_coll    = r_bad;
  assign bus.game_over   = (r_state == S_DEAD);
  assign bus.snake_pixel = r_pixel;
  assign o_dbg_state     = r_state;

endmodule
